// File: rtl/gate16_pkg.sv
// Shared opcodes and FSM encodings for the gate16 arbiter.
// Imported by the arbiter top.
package gate16_pkg;

    localparam logic [1:0] OP_NOT  = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/gate16_arbiter_if.sv
// Request/response bundle between client sequencers
// and the shared gate16 arbiter.
interface gate16_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/gate16_arbiter_rr.sv
// Combinational round-robin arbiter: first requester
// at or after ptr wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);
    int idx;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
            end
        end
    end
endmodule

// File: rtl/gate16_prims.sv
// 16-bit gate primitives used to build the shared
// logic unit.
module Not16 (
    input  logic [15:0] a,
    output logic [15:0] y
);
    assign y = ~a;
endmodule

module And16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    assign y = a & b;
endmodule

module Or16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    assign y = a | b;
endmodule

// File: rtl/gate16_arbiter.sv
// Round-robin front end sharing one 16-bit gate unit
// among NREQ requesters.
module gate16_arbiter
    import gate16_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
) (
    input logic             clk,
    input logic             rst_n,
    gate16_arbiter_if.slave bus
);
    logic [1:0]       state;
    logic [IDW-1:0]   rr_ptr;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IDW-1:0]   id_r;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [WIDTH-1:0] rsp_data;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign bus.req_ready =
        (state == S_IDLE && rst_n) ? gnt : '0;

    assign sel_op = bus.req_op[2*int'(gnt_idx) +: 2];
    assign sel_a  = bus.req_a[WIDTH*int'(gnt_idx) +: WIDTH];
    assign sel_b  = bus.req_b[WIDTH*int'(gnt_idx) +: WIDTH];

    logic [WIDTH-1:0] not_y;
    logic [WIDTH-1:0] and_y;
    logic [WIDTH-1:0] or_y;
    logic [WIDTH-1:0] nand_y;
    logic [WIDTH-1:0] f;

    Not16 u_not  (.a(a_r), .y(not_y));
    And16 u_and  (.a(a_r), .b(b_r), .y(and_y));
    Or16  u_or   (.a(a_r), .b(b_r), .y(or_y));
    Not16 u_nand (.a(and_y), .y(nand_y));

    always_comb begin
        f = not_y;
        unique case (op_r)
            OP_NOT:  f = not_y;
            OP_AND:  f = and_y;
            OP_OR:   f = or_y;
            OP_NAND: f = nand_y;
            default: f = not_y;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            id_r      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|bus.req_valid) begin
                        op_r  <= sel_op;
                        a_r   <= sel_a;
                        b_r   <= sel_b;
                        id_r  <= gnt_idx;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data  <= f;
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (id_r == IDW'(NREQ - 1))
                                   ? '0 : id_r + 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_data  = rsp_data;
endmodule

// File: doc/gate16_arbiter.md
Name: gate16_arbiter

Overview:
- Shares a single 16-bit bitwise logic unit among NREQ requesters, granting them round-robin.
- The unit implements NOT, AND, OR and NAND, built from the team's 16-bit gate primitives.
- Each requester offers an operation over a valid/ready handshake. The block grants one, registers its operands, executes, and returns a tagged response over a second valid/ready handshake.
- It sits between client sequencers and the shared gate datapath so that only one gate16 instance is needed.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, operand and result width.
- IDW, 2, width of the requester index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  NREQ  bit i: requester i offers an operation.
- req_ready  output  NREQ  one-hot or zero; bit i: requester i's offer is accepted this cycle.
- req_op  input  2*NREQ  slice i is the opcode of requester i.
- req_a  input  WIDTH*NREQ  slice i is operand A of requester i.
- req_b  input  WIDTH*NREQ  slice i is operand B of requester i; ignored for NOT.
- rsp_valid  output  1  a response is held.
- rsp_ready  input  1  the consumer accepts the response.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_data  output  WIDTH  result.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-low.
  - Ports are named clk and rst_n.
- Opcodes: 00 = NOT a; 01 = a AND b; 10 = a OR b; 11 = NOT(a AND b).
- FSM states: IDLE, EXEC, RESP.
- Reset (rst_n=0 at a clock edge), also when asserted mid-operation:
  - state = IDLE, rr_ptr = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0.
  - Operand/opcode registers = 0.
  - Any in-flight operation is dropped and no response is produced.
- req_ready:
  - Combinational.
  - Nonzero only in IDLE with rst_n=1.
  - Equals the one-hot grant; the grant is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready is 0 in EXEC and RESP.
- IDLE:
  - If any req_valid: latch the granted requester's op, a, b and the grant index into op_r, a_r, b_r, id_r; go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - rsp_data <= f(op_r, a_r, b_r); rsp_id <= id_r; rsp_valid <= 1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_data stable while rsp_ready = 0.
  - On rsp_valid & rsp_ready: rsp_valid <= 0; rr_ptr <= (id_r + 1) mod NREQ; go to IDLE.
  - rr_ptr wraps from NREQ-1 to 0.
- Latency and throughput:
  - Accept at edge T, rsp_valid high after edge T+1.
  - Maximum one operation per 3 cycles when rsp_ready is held at 1.
- A requester must hold req_valid, op, a and b stable until req_ready; after acceptance it may change them freely.
- Simultaneous requests: exactly one is granted and the others wait; no requester is starved (bounded by NREQ grants).
- Widths: results are exactly WIDTH bits with no extension. The b operand is ignored for NOT, but still latched.
- rsp_ready asserted outside RESP has no effect.
- An index >= NREQ is never generated.

Decomposition:
- Package gate16_pkg holds:
  - the opcode constants OP_NOT, OP_AND, OP_OR, OP_NAND;
  - the FSM state encodings S_IDLE, S_EXEC, S_RESP.
- Sub-module rr_arbiter (NREQ): inputs req and ptr, output one-hot gnt and gnt_idx; purely combinational.
- The logic function f instantiates Not16, And16 and Or16 plus a 4:1 mux inside the top.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_data=16'h0000.
- Single NOT: requester 2, op=00, a=16'h0001 -> req_ready=4'b0100 in that cycle; two edges later rsp_valid=1, rsp_id=2, rsp_data=16'hFFFE.
- All ops on requester 0 with a=16'hF0F0, b=16'hFF00:
  - AND -> 16'hF000;
  - OR -> 16'hFFF0;
  - NAND -> 16'h0FFF.
- Round-robin: all four req_valid held at 1, rsp_ready=1 -> grant order 0,1,2,3,0; rr_ptr wraps from 3 to 0.
- Backpressure: rsp_ready=0 for 5 cycles while in RESP -> rsp_data, rsp_id and rsp_valid are stable and req_ready stays 0; rsp_ready=1 -> handshake completes, and IDLE grants the next requester the following cycle.
- Mid-operation reset: pull rst_n low for 1 cycle during EXEC -> no response appears; rr_ptr=0; the next grant goes to the lowest-index valid requester.
